// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: merges CHANNELS valid/ready producer streams of WIDTH bits into
// one registered output stream. It has two selection modes:
//   - fixed mode: the selector picks the channel.
//   - round-robin mode: arbitration starts at a rotating pointer.
// A word moves from input to output in one cycle. Because the output slot can
// be drained and refilled in the same cycle, throughput is one word per cycle.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   mode         0 = fixed select, 1 = round-robin
//   selector     channel index used in fixed mode
//   in_data      packed inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid     per-channel data valid
//   in_ready     per-channel accept (combinational, at most one bit high)
//   outData      registered selected data
//   out_valid    outData holds an unconsumed word
//   out_ready    consumer accepts outData
//   out_channel  index of the channel that supplied outData
module mux_arb_nto1 #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          outData,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_channel
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             slot_free;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;
    int unsigned      idx;

    assign slot_free = !out_valid || out_ready;

    // Grant selection. The round-robin scan starts at ptr and wraps modulo
    // CHANNELS, so the result is correct even when CHANNELS is not a power of 2.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (!mode) begin
            if ((int'(selector) < CHANNELS) && in_valid[selector]) begin
                grant_valid = 1'b1;
                grant       = selector;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = (int'(ptr) + k) % CHANNELS;
                if (!grant_valid && in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(idx);
                end
            end
        end
    end

    // Reset gates the ready signals, so no handshake can complete while reset is high.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !reset && slot_free && grant_valid && (grant == SEL_W'(i));
        end
    end

    assign xfer = !reset && slot_free && grant_valid;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outData     <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            ptr         <= '0;
        end else begin
            if (xfer) begin
                outData     <= grant_data;
                out_channel <= grant;
                out_valid   <= 1'b1;
                // The pointer only advances on round-robin transfers. Fixed
                // mode leaves it untouched so the rotation resumes where it stopped.
                if (mode) begin
                    if (int'(grant) == CHANNELS - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant + SEL_W'(1);
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nto1.sv
module tb_mux_arb_nto1;

    localparam int WIDTH    = 5;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      mode;
    logic [SEL_W-1:0]          selector;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          outData;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_channel;

    mux_arb_nto1 #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .selector    (selector),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .outData     (outData),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_channel (out_channel)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] ch;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic [WIDTH-1:0] v);
        in_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_xfer(input logic [CHANNELS-1:0] rdy, input logic [WIDTH-1:0] d,
                               input logic [SEL_W-1:0] ch);
        @(negedge clock);
        chk("in_ready", in_ready, rdy);
        q.push_back('{d: d, ch: ch});
    endtask

    // Monitor: every word the consumer takes must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_word", q.size(), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("outData", outData, e.d);
                chk("out_channel", out_channel, e.ch);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with every channel valid and the consumer ready
        reset     = 1'b1;
        mode      = 1'b1;
        selector  = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = '0;
        for (int i = 0; i < CHANNELS; i++) set_ch(i, WIDTH'(i + 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_in_ready", in_ready, 4'b0000);
            if (i > 0) begin
                chk("rst_out_valid", out_valid, 1'b0);
                chk("rst_outData", outData, 5'h00);
                chk("rst_out_channel", out_channel, 2'd0);
            end
            next_cycle();
        end
        reset = 1'b0;

        // 3: round robin with every channel valid, wraps 0,1,2,3,0
        expect_xfer(4'b0001, 5'd1, 2'd0); next_cycle();
        expect_xfer(4'b0010, 5'd2, 2'd1); next_cycle();
        expect_xfer(4'b0100, 5'd3, 2'd2); next_cycle();
        expect_xfer(4'b1000, 5'd4, 2'd3); next_cycle();
        expect_xfer(4'b0001, 5'd1, 2'd0); next_cycle();

        // 2: fixed select of channel 2
        mode     = 1'b0;
        selector = 2'd2;
        set_ch(2, 5'h11);
        in_valid = 4'b0100;
        expect_xfer(4'b0100, 5'h11, 2'd2); next_cycle();
        in_valid = 4'b0000;
        @(negedge clock);
        chk("t2_out_valid", out_valid, 1'b1);
        chk("t2_outData", outData, 5'h11);
        chk("t2_out_channel", out_channel, 2'd2);
        next_cycle();

        // 4: backpressure while holding 5'h07
        selector = 2'd1;
        set_ch(1, 5'h07);
        in_valid = 4'b0010;
        expect_xfer(4'b0010, 5'h07, 2'd1); next_cycle();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            selector = SEL_W'(i + 2);
            @(negedge clock);
            chk("stall_in_ready", in_ready, 4'b0000);
            chk("stall_outData", outData, 5'h07);
            chk("stall_out_channel", out_channel, 2'd1);
            chk("stall_out_valid", out_valid, 1'b1);
            next_cycle();
        end
        out_ready = 1'b1;
        selector  = 2'd3;
        set_ch(3, 5'h0A);
        expect_xfer(4'b1000, 5'h0A, 2'd3); next_cycle();
        in_valid = 4'b0000;
        @(negedge clock);
        chk("t4_outData", outData, 5'h0A);
        chk("t4_out_valid", out_valid, 1'b1);
        next_cycle();

        // 5: round robin wrap scan. ptr is 1 here; granting ch2 moves it to 3.
        mode = 1'b1;
        set_ch(0, 5'h15);
        set_ch(2, 5'h0C);
        in_valid = 4'b0100;
        expect_xfer(4'b0100, 5'h0C, 2'd2); next_cycle();
        in_valid = 4'b0101;
        expect_xfer(4'b0001, 5'h15, 2'd0); next_cycle();
        expect_xfer(4'b0100, 5'h0C, 2'd2); next_cycle();

        // 6: reset while FULL with 5'h1F
        mode     = 1'b0;
        selector = 2'd0;
        set_ch(0, 5'h1F);
        in_valid = 4'b0001;
        expect_xfer(4'b0001, 5'h1F, 2'd0); next_cycle();
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        @(negedge clock);
        chk("t6_full_outData", outData, 5'h1F);
        chk("t6_full_out_valid", out_valid, 1'b1);
        next_cycle();
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        @(negedge clock);
        chk("t6_rst_in_ready", in_ready, 4'b0000);
        q.delete();
        next_cycle();
        reset    = 1'b0;
        selector = 2'd1;
        in_valid = 4'b0101;
        @(negedge clock);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_outData", outData, 5'h00);
        chk("t6_out_channel", out_channel, 2'd0);
        chk("t6_in_ready", in_ready, 4'b0000);
        next_cycle();
        @(negedge clock);
        chk("t6_still_empty", out_valid, 1'b0);
        next_cycle();

        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised successor to the team's 2:1 5-bit multiplexer.
- Generalised to CHANNELS inputs of WIDTH bits each, with a per-channel valid/ready handshake and a registered output stage.
- Two selection modes:
  - Fixed mode: the selector port picks the channel.
  - Round-robin mode: channels are arbitrated fairly.
- Sits between several producer streams and one consumer; merges traffic with 1-cycle latency and full backpressure.

Parameters:
- WIDTH, 5, bit width of each data channel and of outData.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, clog2(CHANNELS), localparam; width of selector, pointer and out_channel. Not user-overridable.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- selector  input  SEL_W  channel index; used only when mode=0.
- in_data  input  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- outData  output  WIDTH  registered selected data.
- out_valid  output  1  outData holds an unconsumed word.
- out_ready  input  1  consumer accepts outData.
- out_channel  output  SEL_W  index of the channel that supplied outData.

Behaviour:
- Reset, applied at a clock edge while reset=1:
  - outData=0, out_valid=0, out_channel=0, round-robin pointer ptr=0.
  - in_ready is forced to all zeros while reset=1.
- Output register state:
  - EMPTY when out_valid=0; FULL when out_valid=1.
  - slot_free = !out_valid || out_ready.
- Grant, combinational:
  - mode=0: the grant is valid iff selector < CHANNELS and in_valid[selector]=1. grant = selector.
  - mode=1: grant = the first index with in_valid=1, scanning ptr, ptr+1, … CHANNELS-1, 0, … ptr-1 (modulo CHANNELS).
  - No valid channel means no grant.
- in_ready:
  - in_ready[i] = slot_free && grant valid && grant==i.
  - At most one in_ready bit is high in any cycle.
- Transfer on channel i (in_valid[i] && in_ready[i]):
  - Next edge: outData <= in_data[i], out_channel <= i, out_valid <= 1.
  - Latency from input transfer to out_valid is 1 cycle.
- Drain:
  - out_valid && out_ready with no new transfer: out_valid <= 0.
  - outData and out_channel hold their last values.
- Simultaneous drain and accept: the register reloads in the same cycle. This gives full throughput of 1 word/cycle.
- Stall:
  - While out_valid && !out_ready, outData and out_channel stay stable and all in_ready bits are 0.
  - Changes to selector or mode during a stall do not alter the held word.
- Pointer update:
  - Only on a transfer in mode=1: ptr <= (grant+1) mod CHANNELS.
  - Wrap: a grant of CHANNELS-1 sets ptr to 0.
  - In mode=0 ptr holds its value.
- Mode switch: takes effect on the next grant evaluation, with no flush. ptr is retained across the switch.
- Non-power-of-2 CHANNELS:
  - selector values >= CHANNELS produce no grant.
  - ptr never exceeds CHANNELS-1.
- Reset mid-operation: a held word is discarded and out_valid=0 the cycle after reset; no handshake completes while reset=1.

Test Plan (WIDTH=5, CHANNELS=4):
1. Reset with in_valid=4'b1111 -> outData=0, out_valid=0, out_channel=0, in_ready=0 throughout reset. The first grant after release (mode=1) goes to channel 0.
2. mode=0, selector=2, in_data ch2=5'h11, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. The next cycle gives outData=5'h11, out_channel=2, out_valid=1.
3. mode=1, all valid, channel i carries value i+1, out_ready=1 held -> out_channel sequence is 0,1,2,3,0 (wrap) and outData is 1,2,3,4,1, one word per cycle.
4. Backpressure: out_ready=0 for 3 cycles while FULL with 5'h07 -> outData stays 5'h07 and in_ready=0. Toggling selector during the stall has no effect. On out_ready=1 the next word loads on the same edge.
5. mode=1, ptr=3, in_valid=4'b0101 -> grant is channel 0 (wrap scan), then ptr=1. The next grant is channel 2.
6. Reset asserted while FULL with 5'h1F -> out_valid=0 and outData=0 after the edge. A mode=0 selector with in_valid[selector]=0 produces no transfer and out_valid stays 0.
